// File: rtl/vgm_pkg.sv
// Shared opcodes, sequencer states and fixed wait lengths for the VGM PSG sequencer.
package vgm_pkg;

   localparam logic [7:0]  OP_PSG   = 8'h50;
   localparam logic [7:0]  OP_GGST  = 8'h4F;
   localparam logic [7:0]  OP_WAIT  = 8'h61;
   localparam logic [7:0]  OP_W735  = 8'h62;
   localparam logic [7:0]  OP_W882  = 8'h63;
   localparam logic [3:0]  OP_WNIB  = 4'h7;  // high nibble of the 0x70-0x7F short waits
   localparam logic [7:0]  OP_END   = 8'h66;

   localparam logic [15:0] WAIT_735 = 16'd735;
   localparam logic [15:0] WAIT_882 = 16'd882;

   typedef enum logic [2:0] {
      StFetch,
      StArg1,
      StArg2,
      StWrHi,
      StWrLo,
      StWait,
      StDone,
      StError
   } seq_state_e;

   // Single-byte wait opcodes: 0x62, 0x63, 0x70-0x7F.
   function automatic logic is_short_wait(input logic [7:0] op);
      return (op == OP_W735) || (op == OP_W882) || (op[7:4] == OP_WNIB);
   endfunction

   // Sample count for a single-byte wait opcode.
   function automatic logic [15:0] short_wait_len(input logic [7:0] op);
      if (op == OP_W735) return WAIT_735;
      if (op == OP_W882) return WAIT_882;
      return {12'd0, op[3:0]} + 16'd1;
   endfunction

endpackage

// File: rtl/vgm_sample_timer.sv
// Sample-tick divider plus a loadable 16-bit wait down-counter.
module vgm_sample_timer
   import vgm_pkg::*;
#(
   parameter logic [15:0] CLK_PER_SAMPLE = 16'd1134
) (
   input  logic        in_clk,
   input  logic        in_reset,
   input  logic        run_i,
   input  logic        load_i,
   input  logic [15:0] count_i,
   output logic        tick_o,
   output logic        expired_o
);

   logic [15:0] div_q, div_d;
   logic [15:0] cnt_q, cnt_d;

   // Free-running divider; the wait counter steps on divider wrap and never goes below zero.
   always_comb begin
      tick_o = run_i && (div_q == CLK_PER_SAMPLE - 16'd1);
      div_d  = div_q;
      if (run_i) begin
         div_d = tick_o ? 16'd0 : div_q + 16'd1;
      end
      cnt_d = cnt_q;
      if (load_i) begin
         cnt_d = count_i;
      end else if (tick_o && (cnt_q != 16'd0)) begin
         cnt_d = cnt_q - 16'd1;
      end
      // Next tick finishes the wait.
      expired_o = (cnt_q <= 16'd1);
   end

   // Divider and counter state.
   always_ff @(posedge in_clk or posedge in_reset) begin
      if (in_reset) begin
         div_q <= 16'd0;
         cnt_q <= 16'd0;
      end else begin
         div_q <= div_d;
         cnt_q <= cnt_d;
      end
   end

endmodule

// File: rtl/vgm_psg_sequencer.sv
// VGM command-stream sequencer: decodes PSG writes, waits and end-of-stream,
// and drives the PSG byte/strobe write interface.
module vgm_psg_sequencer
   import vgm_pkg::*;
#(
   parameter logic [15:0] CLK_PER_SAMPLE = 16'd1134,
   parameter int unsigned WR_PULSE       = 2
) (
   input  logic       in_clk,
   input  logic       in_reset,
   input  logic       in_run,
   input  logic [7:0] in_data,
   input  logic       in_valid,
   output logic       out_ready,
   output logic [7:0] out_val,
   output logic       out_wr,
   output logic       out_waiting,
   output logic       out_done,
   output logic       out_error
);

   localparam logic [15:0] PulseLast = 16'(WR_PULSE - 1);

   seq_state_e  state_q;
   logic        ready_q, wr_q, waiting_q, done_q, error_q;
   logic [7:0]  val_q, op_q, lo_q;
   logic [15:0] pulse_q;

   logic        accept;
   logic        timer_load;
   logic [15:0] timer_count;
   logic        sample_tick;
   logic        timer_expired;

   // out_ready is registered, so a byte offered in the cycle in_run falls is still
   // taken; this keeps the handshake honest and nothing is silently dropped.
   assign accept = in_valid && ready_q;

   // Load the wait counter on a short-wait opcode or when the 0x61 high byte arrives.
   always_comb begin
      timer_load  = 1'b0;
      timer_count = {in_data, lo_q};
      if (accept && (state_q == StFetch) && is_short_wait(in_data)) begin
         timer_load  = 1'b1;
         timer_count = short_wait_len(in_data);
      end else if (accept && (state_q == StArg2)) begin
         timer_load = 1'b1;
      end
   end

   vgm_sample_timer #(
      .CLK_PER_SAMPLE(CLK_PER_SAMPLE)
   ) u_timer (
      .in_clk   (in_clk),
      .in_reset (in_reset),
      .run_i    (in_run),
      .load_i   (timer_load),
      .count_i  (timer_count),
      .tick_o   (sample_tick),
      .expired_o(timer_expired)
   );

   // Command FSM with registered handshake and PSG interface outputs.
   always_ff @(posedge in_clk or posedge in_reset) begin
      if (in_reset) begin
         state_q   <= StFetch;
         ready_q   <= 1'b0;
         wr_q      <= 1'b0;
         waiting_q <= 1'b0;
         done_q    <= 1'b0;
         error_q   <= 1'b0;
         val_q     <= 8'd0;
         op_q      <= 8'd0;
         lo_q      <= 8'd0;
         pulse_q   <= 16'd0;
      end else begin
         case (state_q)
            StFetch: begin
               ready_q <= in_run;
               if (accept) begin
                  op_q <= in_data;
                  if ((in_data == OP_PSG) || (in_data == OP_GGST) || (in_data == OP_WAIT)) begin
                     state_q <= StArg1;
                  end else if (is_short_wait(in_data)) begin
                     state_q   <= StWait;
                     waiting_q <= 1'b1;
                     ready_q   <= 1'b0;
                  end else if (in_data == OP_END) begin
                     state_q <= StDone;
                     done_q  <= 1'b1;
                     ready_q <= 1'b0;
                  end else begin
                     state_q <= StError;
                     error_q <= 1'b1;
                     ready_q <= 1'b0;
                  end
               end
            end
            StArg1: begin
               ready_q <= in_run;
               if (accept) begin
                  if (op_q == OP_PSG) begin
                     state_q <= StWrHi;
                     val_q   <= in_data;
                     wr_q    <= 1'b1;
                     pulse_q <= 16'd0;
                     ready_q <= 1'b0;
                  end else if (op_q == OP_GGST) begin
                     state_q <= StFetch;
                  end else begin
                     state_q <= StArg2;
                     lo_q    <= in_data;
                  end
               end
            end
            StArg2: begin
               ready_q <= in_run;
               if (accept) begin
                  if ({in_data, lo_q} == 16'd0) begin
                     state_q <= StFetch;
                  end else begin
                     state_q   <= StWait;
                     waiting_q <= 1'b1;
                     ready_q   <= 1'b0;
                  end
               end
            end
            StWrHi: begin
               if (in_run) begin
                  if (pulse_q == PulseLast) begin
                     state_q <= StWrLo;
                     wr_q    <= 1'b0;
                     pulse_q <= 16'd0;
                  end else begin
                     pulse_q <= pulse_q + 16'd1;
                  end
               end
            end
            StWrLo: begin
               if (in_run) begin
                  if (pulse_q == PulseLast) begin
                     state_q <= StFetch;
                     ready_q <= 1'b1;
                  end else begin
                     pulse_q <= pulse_q + 16'd1;
                  end
               end
            end
            StWait: begin
               // Leave on the tick that brings the count to zero.
               if (sample_tick && timer_expired) begin
                  state_q   <= StFetch;
                  waiting_q <= 1'b0;
                  ready_q   <= 1'b1;
               end
            end
            StDone, StError: begin
               ready_q <= 1'b0;
            end
            default: begin
               state_q <= StError;
               error_q <= 1'b1;
               ready_q <= 1'b0;
            end
         endcase
      end
   end

   assign out_ready   = ready_q;
   assign out_val     = val_q;
   assign out_wr      = wr_q;
   assign out_waiting = waiting_q;
   assign out_done    = done_q;
   assign out_error   = error_q;

endmodule

// File: tb/tb_vgm_psg_sequencer.sv
// Bench for vgm_psg_sequencer: directed scenarios plus a randomized command stream,
// checked every cycle against a transaction-level model of the command stream.
module tb_vgm_psg_sequencer;

   localparam int CPS = 4;
   localparam int WRP = 2;

   logic       in_clk   = 1'b0;
   logic       in_reset = 1'b1;
   logic       in_run   = 1'b1;
   logic [7:0] in_data  = 8'd0;
   logic       in_valid = 1'b0;
   logic       out_ready, out_wr, out_waiting, out_done, out_error;
   logic [7:0] out_val;

   vgm_psg_sequencer #(
      .CLK_PER_SAMPLE(16'(CPS)),
      .WR_PULSE      (WRP)
   ) dut (
      .in_clk     (in_clk),
      .in_reset   (in_reset),
      .in_run     (in_run),
      .in_data    (in_data),
      .in_valid   (in_valid),
      .out_ready  (out_ready),
      .out_val    (out_val),
      .out_wr     (out_wr),
      .out_waiting(out_waiting),
      .out_done   (out_done),
      .out_error  (out_error)
   );

   always #5 in_clk = ~in_clk;

   int n_checks = 0;
   int n_errors = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic check_range(input string name, input int act, input int lo, input int hi);
      n_checks++;
      if (act < lo || act > hi) begin
         n_errors++;
         $display("FAIL %s: got %0d, expected %0d..%0d at %0t", name, act, lo, hi, $time);
      end
   endtask

   // ---------------- behavioural model ----------------
   // Counts remaining write cycles and remaining sample ticks rather than states.
   int unsigned m_runs    = 0;  // in_run cycles since reset; tick on each CPS-th
   int          m_wr_left = 0;  // cycles left of the 2*WRP write slot
   int          m_ticks   = 0;  // sample ticks left in the current wait
   int          m_nbytes  = 0;  // bytes of the current command already taken
   logic [7:0]  m_op = 8'd0, m_lo = 8'd0;
   logic        exp_ready = 0, exp_wr = 0, exp_waiting = 0, exp_done = 0, exp_error = 0;
   logic [7:0]  exp_val = 8'd0;

   task automatic consume(input logic [7:0] b);
      if (m_nbytes == 0) begin
         m_op = b;
         if (b == 8'h50 || b == 8'h4F || b == 8'h61) m_nbytes = 1;
         else if (b == 8'h62) m_ticks = 735;
         else if (b == 8'h63) m_ticks = 882;
         else if (b[7:4] == 4'h7) m_ticks = int'(b[3:0]) + 1;
         else if (b == 8'h66) exp_done = 1'b1;
         else exp_error = 1'b1;
      end else if (m_nbytes == 1) begin
         if (m_op == 8'h50) begin
            exp_val   = b;
            m_wr_left = 2 * WRP;
            m_nbytes  = 0;
         end else if (m_op == 8'h4F) begin
            m_nbytes = 0;
         end else begin
            m_lo     = b;
            m_nbytes = 2;
         end
      end else begin
         m_ticks  = int'(b) * 256 + int'(m_lo);
         m_nbytes = 0;
      end
   endtask

   task automatic model_step();
      bit tick, accept;
      if (in_reset) begin
         m_runs = 0; m_wr_left = 0; m_ticks = 0; m_nbytes = 0;
         exp_ready = 0; exp_wr = 0; exp_waiting = 0; exp_done = 0; exp_error = 0;
         exp_val = 8'd0;
         return;
      end
      tick   = in_run && ((m_runs % CPS) == CPS - 1);
      accept = in_valid && exp_ready;
      if (in_run) m_runs++;
      if (m_wr_left > 0) begin
         if (in_run) m_wr_left--;
      end else if (m_ticks > 0) begin
         if (tick) m_ticks--;
      end else if (accept) begin
         consume(in_data);
      end
      exp_wr      = (m_wr_left > WRP);
      exp_waiting = (m_ticks > 0);
      exp_ready   = in_run && m_wr_left == 0 && m_ticks == 0 && !exp_done && !exp_error;
   endtask

   initial forever begin
      @(posedge in_clk or posedge in_reset);
      model_step();
   end

   // ---------------- per-cycle compare and monitors ----------------
   int         wait_cycles = 0;
   int         wr_hi_cycles = 0;
   logic       wr_prev = 1'b0;
   logic [7:0] wr_log[$];

   initial forever begin
      @(negedge in_clk);
      check("ready",   out_ready,   exp_ready);
      check("wr",      out_wr,      exp_wr);
      check("val",     out_val,     exp_val);
      check("waiting", out_waiting, exp_waiting);
      check("done",    out_done,    exp_done);
      check("error",   out_error,   exp_error);
      if (out_waiting) wait_cycles++;
      if (out_wr) wr_hi_cycles++;
      if (out_wr && !wr_prev) wr_log.push_back(out_val);
      wr_prev = out_wr;
   end

   // Random in_run toggling during the random phase.
   bit rand_run = 0;
   initial forever begin
      @(posedge in_clk);
      #1;
      if (rand_run) in_run = ($urandom_range(0, 9) != 0);
   end

   initial begin
      repeat (80000) @(posedge in_clk);
      n_errors++;
      $display("FAIL watchdog: cycle budget expired");
      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

   // ---------------- drivers ----------------
   // All driver tasks start and end 1 time unit after a rising edge.
   task automatic send_byte(input logic [7:0] b, input int gap);
      bit acc = 0;
      if (gap > 0) begin
         in_valid = 1'b0;
         repeat (gap) begin @(posedge in_clk); #1; end
      end
      in_valid = 1'b1;
      in_data  = b;
      for (int i = 0; i < 4000 && !acc; i++) begin
         @(negedge in_clk);
         acc = out_ready;
         @(posedge in_clk);
         #1;
      end
      if (!acc) check("accept_timeout", 32'(acc), 32'd1);
   endtask

   task automatic idle_until_ready(input int budget);
      bit rdy = 0;
      in_valid = 1'b0;
      for (int i = 0; i < budget && !rdy; i++) begin
         @(negedge in_clk);
         rdy = out_ready;
      end
      if (!rdy) check("ready_timeout", 32'(rdy), 32'd1);
      @(posedge in_clk);
      #1;
   endtask

   task automatic do_reset();
      in_valid = 1'b0;
      in_reset = 1'b1;
      repeat (3) @(posedge in_clk);
      #1 in_reset = 1'b0;
   endtask

   task automatic measure_wait(input string name, input logic [7:0] op, input int lo, input int hi);
      wait_cycles = 0;
      send_byte(op, 0);
      idle_until_ready(4000);
      check_range(name, wait_cycles, lo, hi);
   endtask

   task automatic write_pair(input int gap);
      wr_log.delete();
      send_byte(8'h50, gap);
      send_byte(8'h80, gap);
      send_byte(8'h50, gap);
      send_byte(8'h05, gap);
      idle_until_ready(50);
      check("pair_count", wr_log.size(), 2);
      if (wr_log.size() == 2) begin
         check("pair_first", wr_log[0], 8'h80);
         check("pair_second", wr_log[1], 8'h05);
      end
   endtask

   task automatic lockout(input string name);
      int seen = 0;
      in_valid = 1'b1;
      in_data  = 8'h50;
      repeat (100) begin
         @(negedge in_clk);
         seen += int'(out_ready);
      end
      check(name, seen, 0);
      @(posedge in_clk);
      #1 in_valid = 1'b0;
   endtask

   // ---------------- main sequence ----------------
   initial begin
      @(negedge in_clk);
      check("rst_ready", out_ready, 1'b0);
      check("rst_val", out_val, 8'h00);
      check("rst_wr", out_wr, 1'b0);
      check("rst_waiting", out_waiting, 1'b0);
      check("rst_done", out_done, 1'b0);
      check("rst_error", out_error, 1'b0);
      @(posedge in_clk);
      #1 in_reset = 1'b0;

      // Single PSG write.
      wr_log.delete();
      wr_hi_cycles = 0;
      send_byte(8'h50, 0);
      send_byte(8'h9F, 0);
      idle_until_ready(50);
      check("w1_edges", wr_log.size(), 1);
      check("w1_val", out_val, 8'h9F);
      check("w1_hi_cycles", wr_hi_cycles, 2);

      // 0x61 waits: 3 samples, then zero samples.
      wait_cycles = 0;
      send_byte(8'h61, 0);
      send_byte(8'h03, 0);
      send_byte(8'h00, 0);
      idle_until_ready(200);
      check_range("wait3_cycles", wait_cycles, 9, 12);
      wait_cycles = 0;
      send_byte(8'h61, 0);
      send_byte(8'h00, 0);
      send_byte(8'h00, 0);
      in_valid = 1'b0;
      @(negedge in_clk);
      check("wait0_ready", out_ready, 1'b1);
      check("wait0_cycles", wait_cycles, 0);
      @(posedge in_clk);
      #1;

      // Short waits.
      measure_wait("w70_cycles", 8'h70, 1, 4);
      measure_wait("w7f_cycles", 8'h7F, 61, 64);
      measure_wait("w62_cycles", 8'h62, 2937, 2940);

      // Game Gear stereo byte produces no write.
      wr_log.delete();
      send_byte(8'h4F, 0);
      send_byte(8'hFF, 0);
      idle_until_ready(50);
      check("ggst_no_write", wr_log.size(), 0);

      // Back-to-back writes, then with gaps.
      write_pair(0);
      write_pair(5);

      // End of stream and unsupported opcode lock out further bytes.
      send_byte(8'h66, 0);
      lockout("done_lockout");
      check("done_flag", out_done, 1'b1);
      do_reset();
      send_byte(8'hA0, 0);
      lockout("error_lockout");
      check("error_flag", out_error, 1'b1);
      do_reset();

      // Reset during a 500-sample wait.
      send_byte(8'h61, 0);
      send_byte(8'hF4, 0);
      send_byte(8'h01, 0);
      in_valid = 1'b0;
      repeat (20) @(posedge in_clk);
      #2 check("mid_wait_before", out_waiting, 1'b1);
      #1 in_reset = 1'b1;
      #1 check("mid_wait_after", out_waiting, 1'b0);
      repeat (2) @(posedge in_clk);
      #1 in_reset = 1'b0;
      wr_log.delete();
      send_byte(8'h50, 0);
      send_byte(8'h44, 0);
      idle_until_ready(50);
      check("post_wait_rst_write", wr_log.size(), 1);
      if (wr_log.size() == 1) check("post_wait_rst_val", wr_log[0], 8'h44);

      // Reset during the write-high phase.
      send_byte(8'h50, 0);
      send_byte(8'h33, 0);
      in_valid = 1'b0;
      #1 check("mid_wr_before", out_wr, 1'b1);
      #1 in_reset = 1'b1;
      #1 check("mid_wr_after", out_wr, 1'b0);
      repeat (2) @(posedge in_clk);
      #1 in_reset = 1'b0;
      send_byte(8'h66, 0);
      in_valid = 1'b0;
      @(negedge in_clk);
      check("post_wr_rst_opcode", out_done, 1'b1);
      @(posedge in_clk);
      #1;
      do_reset();

      // Randomized stream with gaps and in_run stalls.
      rand_run = 1;
      for (int c = 0; c < 40; c++) begin
         case ($urandom_range(0, 3))
            0: begin
               send_byte(8'h50, $urandom_range(0, 3));
               send_byte(8'($urandom_range(0, 255)), $urandom_range(0, 3));
            end
            1: begin
               send_byte(8'h4F, $urandom_range(0, 3));
               send_byte(8'($urandom_range(0, 255)), $urandom_range(0, 3));
            end
            2: begin
               send_byte(8'h61, $urandom_range(0, 3));
               send_byte(8'($urandom_range(0, 6)), $urandom_range(0, 3));
               send_byte(8'h00, $urandom_range(0, 3));
            end
            default: send_byte(8'h70 | 8'($urandom_range(0, 3)), $urandom_range(0, 3));
         endcase
      end
      in_valid = 1'b0;
      rand_run = 0;
      @(posedge in_clk);
      #2 in_run = 1'b1;
      idle_until_ready(500);
      check("rand_end_ready", out_ready, 1'b1);

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule

// File: doc/vgm_psg_sequencer.md
Name: vgm_psg_sequencer

Overview:
Upstream command stage for the PSG core. It consumes a VGM command byte stream over a valid/ready handshake and decodes PSG writes, waits and end-of-stream. It drives the PSG byte/strobe write interface (val, wr) with correct edge spacing. Waits are paced by an internal 44.1 kHz-equivalent sample tick derived from in_clk.

Parameters:
CLK_PER_SAMPLE, 16'd1134, in_clk cycles per VGM sample tick (50 MHz / 44.1 kHz); must be >= 1.
WR_PULSE, 2, cycles out_wr is held high, and then held low, per PSG write; must be >= 1.

Ports:
in_clk  input  1  clock.
in_reset  input  1  reset: asynchronous, active-high.
in_run  input  1  1 = sequencer advances; 0 = freeze (no byte accepted, tick and wait counters hold).
in_data  input  8  VGM stream byte.
in_valid  input  1  in_data valid.
out_ready  output  1  byte accepted on a cycle where in_valid && out_ready.
out_val  output  8  PSG data byte; drives the PSG core's in_val.
out_wr  output  1  PSG write strobe; drives the PSG core's in_wr (consumer is rising-edge sensitive).
out_waiting  output  1  high while a wait is counting.
out_done  output  1  sticky; 0x66 seen.
out_error  output  1  sticky; unsupported opcode seen.

Behaviour:
- Reset (async) values: state=FETCH, out_val=0, out_wr=0, out_ready=0, out_waiting=0, out_done=0, out_error=0; tick counter=0, wait counter=0.
- out_ready is registered. It is 1 only in FETCH/ARG1/ARG2 with in_run=1; it deasserts in the cycle after any accept that leaves the arg states.
- Opcodes, decoded in FETCH:
  - 0x50 dd: write dd to PSG.
  - 0x4F dd: Game Gear stereo byte; consumed and discarded.
  - 0x61 lo hi: wait {hi,lo} samples.
  - 0x62: wait 735 samples.
  - 0x63: wait 882 samples.
  - 0x70-0x7F: wait (n+1) samples.
  - 0x66: enter DONE.
  - Any other opcode: enter ERROR.
- States:
  - FETCH -> ARG1 (0x50/0x4F/0x61), WAIT (0x62/0x63/0x7n), DONE, or ERROR.
  - ARG1 -> WR_HI (0x50), FETCH (0x4F), or ARG2 (0x61, low byte latched).
  - ARG2 -> WAIT with count={hi,lo}; a count of 0 goes straight to FETCH.
  - WR_HI: out_val=dd, out_wr=1 for WR_PULSE cycles -> WR_LO.
  - WR_LO: out_wr=0 for WR_PULSE cycles -> FETCH. out_val holds dd until the next write.
  - WAIT: counter decrements on each sample tick; leave to FETCH in the cycle after the tick that takes it to 0. A wait of N lasts N ticks (+0..CLK_PER_SAMPLE-1 cycles of phase).
  - DONE and ERROR are terminal until reset; out_ready=0 in both.
- Sample tick: free-running counter 0..CLK_PER_SAMPLE-1 that pulses at wrap. It is not reset on wait entry, and runs only when in_run=1.
- in_run=0: freezes state, tick and wait counters. WR_HI/WR_LO timers also freeze, holding out_wr at its current level.
- in_valid gaps between opcode and args: the sequencer stays in ARG1/ARG2 indefinitely.
- Wait counter is 16 bits; 0xFFFF must not wrap.
- Reset mid-write: out_wr drops to 0 immediately (async).

Decomposition:
- Package vgm_pkg holds:
  - opcode constants: OP_PSG=0x50, OP_GGST=0x4F, OP_WAIT=0x61, OP_W735=0x62, OP_W882=0x63, OP_WNIB=0x7?, OP_END=0x66;
  - the state enum (FETCH, ARG1, ARG2, WR_HI, WR_LO, WAIT, DONE, ERROR);
  - the wait constants 735 and 882.
- Sub-module vgm_sample_timer: tick divider plus 16-bit loadable wait down-counter, with ports load, count, run, tick, expired.

Test Plan:
- CLK_PER_SAMPLE=4, WR_PULSE=2; stream 0x50,0x9F -> out_val=0x9F, out_wr high exactly 2 cycles then low 2 cycles, out_ready returns 1 after; exactly one rising edge of out_wr.
- Stream 0x61,0x03,0x00 -> out_waiting high for 3 ticks (9-12 cycles), out_ready=0 throughout. Then 0x61,0x00,0x00 -> no wait, out_ready stays 1.
- 0x70 -> one tick of waiting; 0x7F -> 16 ticks; 0x62 -> 735 ticks (2937-2940 cycles at CLK_PER_SAMPLE=4).
- 0x50,0x80,0x50,0x05 back-to-back with in_valid always 1 -> two distinct wr edges, out_val 0x80 then 0x05. Repeat with 5-cycle in_valid gaps -> identical PSG writes.
- 0x66 -> out_done=1 and out_ready=0 for 100 cycles despite in_valid=1. Separately, 0xA0 -> out_error=1 with the same lockout.
- Assert in_reset during WAIT (count 500) and during WR_HI -> out_wr and out_waiting drop immediately. After release the next byte is decoded as an opcode in FETCH.
